// File: rtl/ddr2_v10_1_0002_sequencer_rw_mgr_master.sv
// Avalon-MM initiator issuing single read/write transactions from the
// calibration sequencer into the rw_mgr Avalon slave port.
//
// Ports:
//   avl_clk, avl_reset             clock, asynchronous active-high reset
//   req_valid/req_ready            request handshake (one request at a time)
//   req_write/req_address/req_wdata request payload, sampled at handshake
//   rsp_valid/rsp_rdata/rsp_timeout one-cycle completion pulse + qualifiers
//   err_sticky/err_clear           sticky timeout flag and its clear
//   busy                           high whenever not IDLE
//   avl_*                          Avalon-MM initiator signals
module ddr2_v10_1_0002_sequencer_rw_mgr_master #(
  parameter int unsigned AVL_DATA_WIDTH    = 32,
  parameter int unsigned AVL_ADDRESS_WIDTH = 16,
  parameter int unsigned TIMEOUT_CYCLES    = 65535
) (
  input  logic                         avl_clk,
  input  logic                         avl_reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [AVL_ADDRESS_WIDTH-1:0] req_address,
  input  logic [AVL_DATA_WIDTH-1:0]    req_wdata,
  output logic                         rsp_valid,
  output logic [AVL_DATA_WIDTH-1:0]    rsp_rdata,
  output logic                         rsp_timeout,
  output logic                         err_sticky,
  input  logic                         err_clear,
  output logic                         busy,
  output logic [AVL_ADDRESS_WIDTH-1:0] avl_address,
  output logic                         avl_write,
  output logic [AVL_DATA_WIDTH-1:0]    avl_writedata,
  output logic                         avl_read,
  input  logic [AVL_DATA_WIDTH-1:0]    avl_readdata,
  input  logic                         avl_waitrequest
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_MAX   = {WD_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic                           req_ready_q, req_ready_d;
  logic                           rsp_valid_q, rsp_valid_d;
  logic [AVL_DATA_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic                           rsp_timeout_q, rsp_timeout_d;
  logic                           err_sticky_q, err_sticky_d;
  logic                           busy_q, busy_d;
  logic [AVL_ADDRESS_WIDTH-1:0]   avl_address_q, avl_address_d;
  logic                           avl_write_q, avl_write_d;
  logic [AVL_DATA_WIDTH-1:0]      avl_writedata_q, avl_writedata_d;
  logic                           avl_read_q, avl_read_d;
  logic [WD_W-1:0]                wd_q, wd_d;
  logic [WD_W-1:0]                wd_inc;

  // State and output registers
  always_ff @(posedge avl_clk or posedge avl_reset) begin
    if (avl_reset) begin
      state_q         <= ST_IDLE;
      req_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      rsp_timeout_q   <= 1'b0;
      err_sticky_q    <= 1'b0;
      busy_q          <= 1'b0;
      avl_address_q   <= '0;
      avl_write_q     <= 1'b0;
      avl_writedata_q <= '0;
      avl_read_q      <= 1'b0;
      wd_q            <= '0;
    end else begin
      state_q         <= state_d;
      req_ready_q     <= req_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_timeout_q   <= rsp_timeout_d;
      err_sticky_q    <= err_sticky_d;
      busy_q          <= busy_d;
      avl_address_q   <= avl_address_d;
      avl_write_q     <= avl_write_d;
      avl_writedata_q <= avl_writedata_d;
      avl_read_q      <= avl_read_d;
      wd_q            <= wd_d;
    end
  end

  // Saturating watchdog increment
  assign wd_inc = (wd_q == WD_MAX) ? wd_q : WD_W'(wd_q + 1'b1);

  // Next-state and next-output logic
  always_comb begin
    state_d         = state_q;
    rsp_valid_d     = 1'b0;
    rsp_rdata_d     = '0;
    rsp_timeout_d   = 1'b0;
    err_sticky_d    = err_clear ? 1'b0 : err_sticky_q;
    avl_address_d   = avl_address_q;
    avl_write_d     = avl_write_q;
    avl_writedata_d = avl_writedata_q;
    avl_read_d      = avl_read_q;
    wd_d            = wd_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          avl_address_d   = req_address;
          avl_writedata_d = req_wdata;
          avl_write_d     = req_write;
          avl_read_d      = ~req_write;
          wd_d            = '0;
          state_d         = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Completion is checked first so it wins over a same-edge timeout
        if (!avl_waitrequest) begin
          avl_write_d = 1'b0;
          avl_read_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = avl_read_q ? avl_readdata : '0;
          state_d     = ST_GAP;
        end else begin
          wd_d = wd_inc;
          if (wd_inc == WD_LIMIT) begin
            avl_write_d   = 1'b0;
            avl_read_d    = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            err_sticky_d  = 1'b1;
            state_d       = ST_GAP;
          end
        end
      end
      // One cycle with both strobes low so the slave returns to idle
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        avl_write_d = 1'b0;
        avl_read_d  = 1'b0;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign err_sticky    = err_sticky_q;
  assign busy          = busy_q;
  assign avl_address   = avl_address_q;
  assign avl_write     = avl_write_q;
  assign avl_writedata = avl_writedata_q;
  assign avl_read      = avl_read_q;

endmodule

// File: tb/tb_ddr2_v10_1_0002_sequencer_rw_mgr_master.sv
// Directed self-checking bench for the rw_mgr Avalon initiator (TIMEOUT_CYCLES=8).
module tb_ddr2_v10_1_0002_sequencer_rw_mgr_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_address;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_timeout, err_sticky, err_clear, busy;
  logic [31:0] rsp_rdata;
  logic [15:0] avl_address;
  logic        avl_write, avl_read, avl_waitrequest;
  logic [31:0] avl_writedata, avl_readdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ddr2_v10_1_0002_sequencer_rw_mgr_master #(
    .AVL_DATA_WIDTH(32), .AVL_ADDRESS_WIDTH(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .avl_clk(clk), .avl_reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .err_sticky(err_sticky), .err_clear(err_clear), .busy(busy),
    .avl_address(avl_address), .avl_write(avl_write),
    .avl_writedata(avl_writedata), .avl_read(avl_read),
    .avl_readdata(avl_readdata), .avl_waitrequest(avl_waitrequest)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge, then park on the falling edge for sampling/driving
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic wr, input logic [15:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_write = wr; req_address = a; req_wdata = d;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_address = '0;
    req_wdata = '0; err_clear = 1'b0; avl_waitrequest = 1'b0; avl_readdata = '0;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_avl_read", 32'(avl_read), 32'd0);
    chk("rst_avl_write", 32'(avl_write), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_err", 32'(err_sticky), 32'd0);
    chk("rst_addr", 32'(avl_address), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Read, zero wait
    avl_waitrequest = 1'b0; avl_readdata = 32'hA5A5_0001;
    issue(1'b0, 16'h6000, 32'h0);
    chk("rd0_read", 32'(avl_read), 32'd1);
    chk("rd0_write", 32'(avl_write), 32'd0);
    chk("rd0_addr", 32'(avl_address), 32'h6000);
    chk("rd0_ready", 32'(req_ready), 32'd0);
    chk("rd0_busy", 32'(busy), 32'd1);
    chk("rd0_rspv_early", 32'(rsp_valid), 32'd0);
    step();
    chk("rd0_read_low", 32'(avl_read), 32'd0);
    chk("rd0_rspv", 32'(rsp_valid), 32'd1);
    chk("rd0_rdata", rsp_rdata, 32'hA5A5_0001);
    chk("rd0_tmo", 32'(rsp_timeout), 32'd0);
    chk("rd0_gap_ready", 32'(req_ready), 32'd0);
    step();
    chk("rd0_rspv_once", 32'(rsp_valid), 32'd0);
    chk("rd0_ready_back", 32'(req_ready), 32'd1);
    chk("rd0_busy_idle", 32'(busy), 32'd0);

    // Write with 5 wait cycles, req_valid held with changing data meanwhile
    avl_waitrequest = 1'b1; avl_readdata = 32'hDEAD_BEEF;
    issue(1'b1, 16'h4000, 32'h0000_0012);
    req_valid = 1'b1; req_write = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_address = 16'h1000 + 16'(i); req_wdata = 32'h7700_0000 + 32'(i);
      chk("wr5_write", 32'(avl_write), 32'd1);
      chk("wr5_addr", 32'(avl_address), 32'h4000);
      chk("wr5_wdata", avl_writedata, 32'h0000_0012);
      chk("wr5_ready", 32'(req_ready), 32'd0);
      chk("wr5_rspv", 32'(rsp_valid), 32'd0);
      if (i == 5) avl_waitrequest = 1'b0;
      step();
    end
    chk("wr5_write_low", 32'(avl_write), 32'd0);
    chk("wr5_read_low", 32'(avl_read), 32'd0);
    chk("wr5_rspv", 32'(rsp_valid), 32'd1);
    chk("wr5_rdata", rsp_rdata, 32'h0);
    chk("wr5_tmo", 32'(rsp_timeout), 32'd0);
    avl_readdata = 32'h0BAD_F00D;
    step();
    // Second low cycle; pending request (addr 0x1005) is taken at this edge
    chk("wr5_gap2_write", 32'(avl_write), 32'd0);
    chk("wr5_gap2_read", 32'(avl_read), 32'd0);
    chk("wr5_gap2_ready", 32'(req_ready), 32'd1);
    chk("wr5_rspv_once", 32'(rsp_valid), 32'd0);
    step();
    req_valid = 1'b0;
    chk("bp_read", 32'(avl_read), 32'd1);
    chk("bp_addr", 32'(avl_address), 32'h1005);
    step();
    chk("bp_rspv", 32'(rsp_valid), 32'd1);
    chk("bp_rdata", rsp_rdata, 32'h0BAD_F00D);
    step();

    // Timeout: waitrequest stuck high
    avl_waitrequest = 1'b1; avl_readdata = 32'h1111_2222;
    issue(1'b0, 16'h2000, 32'h0);
    for (int i = 0; i < 8; i++) begin
      chk("tmo_read_hi", 32'(avl_read), 32'd1);
      chk("tmo_rspv_lo", 32'(rsp_valid), 32'd0);
      step();
    end
    chk("tmo_read_low", 32'(avl_read), 32'd0);
    chk("tmo_rspv", 32'(rsp_valid), 32'd1);
    chk("tmo_flag", 32'(rsp_timeout), 32'd1);
    chk("tmo_rdata", rsp_rdata, 32'h0);
    chk("tmo_err", 32'(err_sticky), 32'd1);
    step();
    chk("tmo_err_hold", 32'(err_sticky), 32'd1);
    chk("tmo_ready", 32'(req_ready), 32'd1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("tmo_err_cleared", 32'(err_sticky), 32'd0);

    // Timeout with err_clear on the timeout edge: set wins
    issue(1'b0, 16'h2004, 32'h0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) err_clear = 1'b1;
      step();
    end
    err_clear = 1'b0;
    chk("tmo2_flag", 32'(rsp_timeout), 32'd1);
    chk("tmo2_err_set_wins", 32'(err_sticky), 32'd1);
    step();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("tmo2_err_cleared", 32'(err_sticky), 32'd0);

    // Race: waitrequest falls on the 8th strobe cycle
    issue(1'b0, 16'h2008, 32'h0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin avl_waitrequest = 1'b0; avl_readdata = 32'h5A5A_0008; end
      chk("race_read_hi", 32'(avl_read), 32'd1);
      step();
    end
    chk("race_rspv", 32'(rsp_valid), 32'd1);
    chk("race_tmo", 32'(rsp_timeout), 32'd0);
    chk("race_rdata", rsp_rdata, 32'h5A5A_0008);
    chk("race_err", 32'(err_sticky), 32'd0);
    step();

    // Reset mid-ACCESS of a stalled write
    avl_waitrequest = 1'b1;
    issue(1'b1, 16'h4444, 32'hCAFE_0001);
    chk("rma_write_c1", 32'(avl_write), 32'd1);
    step();
    chk("rma_write_c2", 32'(avl_write), 32'd1);
    rst = 1'b1;
    #1;
    chk("rma_write_async", 32'(avl_write), 32'd0);
    chk("rma_busy", 32'(busy), 32'd0);
    chk("rma_ready_in_rst", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    avl_waitrequest = 1'b0;
    step();
    chk("rma_rspv", 32'(rsp_valid), 32'd0);
    chk("rma_ready", 32'(req_ready), 32'd1);
    chk("rma_write_low", 32'(avl_write), 32'd0);
    step();
    chk("rma_rspv2", 32'(rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
